// File: rtl/router_pkg.sv
// router_pkg: shared constants for the router datapath register stage.
//   DEFAULT_DATA_WIDTH   default byte width of the datapath
//   ADDR_INVALID         destination address that is never captured
//   ADDR_LSB/ADDR_MSB    header destination-address field
//   LEN_LSB              header payload-length field LSB (length runs to the MSB)
//   addr_valid()         true when a header address may be captured
package router_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam logic [1:0]  ADDR_INVALID       = 2'b11;
  localparam int unsigned ADDR_LSB           = 0;
  localparam int unsigned ADDR_MSB           = 1;
  localparam int unsigned LEN_LSB            = 2;

  function automatic logic addr_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk: running packet parity, parity-byte capture and parity check.
// Optional macro PARITY_ERR_CNT_EN adds a saturating 8-bit parity-error counter;
// without it o_err_cnt is tied to zero.
// Ports:
//   i_clk, i_resetn        clock, asynchronous active-low reset
//   i_detect_add .. i_rst_int_reg   FSM state strobes
//   i_pkt_valid, i_fifo_full        source valid, selected FIFO full
//   i_data_in              source byte
//   i_header_hold          captured header (folded into parity in LOAD_FIRST_DATA)
//   i_low_pkt_valid        pkt_valid fell while loading data
//   o_parity_done          parity byte captured
//   o_err                  parity mismatch for the current packet
//   o_err_cnt              saturating count of parity errors
module router_parity_chk
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_detect_add,
  input  logic                  i_lfd_state,
  input  logic                  i_ld_state,
  input  logic                  i_laf_state,
  input  logic                  i_full_state,
  input  logic                  i_rst_int_reg,
  input  logic                  i_pkt_valid,
  input  logic                  i_fifo_full,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [DATA_WIDTH-1:0] i_header_hold,
  input  logic                  i_low_pkt_valid,
  output logic                  o_parity_done,
  output logic                  o_err,
  output logic [7:0]            o_err_cnt
);

  logic [DATA_WIDTH-1:0] r_int_parity;
  logic [DATA_WIDTH-1:0] r_pkt_parity;
  logic                  r_parity_done;
  logic                  r_err;
  logic                  w_par_strobe;
  logic                  w_mismatch;
  logic                  w_check;

  // Parity byte arrives either directly in LOAD_DATA, or, if the FIFO was full
  // when pkt_valid fell, later via LOAD_AFTER_FULL (source keeps it on data_in).
  assign w_par_strobe = (i_ld_state && !i_fifo_full && !i_pkt_valid) ||
                        (i_laf_state && i_low_pkt_valid && !r_parity_done);
  assign w_mismatch   = r_int_parity != r_pkt_parity;
  assign w_check      = !i_detect_add && r_parity_done && i_rst_int_reg;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_int_parity  <= '0;
      r_pkt_parity  <= '0;
      r_parity_done <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (i_detect_add)
        r_int_parity <= '0;
      else if (i_lfd_state)
        r_int_parity <= r_int_parity ^ i_header_hold;
      else if (i_ld_state && i_pkt_valid && !i_full_state)
        r_int_parity <= r_int_parity ^ i_data_in;

      if (w_par_strobe)
        r_pkt_parity <= i_data_in;

      if (i_detect_add)
        r_parity_done <= 1'b0;
      else if (w_par_strobe)
        r_parity_done <= 1'b1;

      if (i_detect_add)
        r_err <= 1'b0;
      else if (w_check)
        r_err <= w_mismatch;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Counts on the same edge err rises, so no delayed copy of err is needed.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      r_err_cnt <= '0;
    else if (w_check && w_mismatch && !r_err && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  assign o_parity_done = r_parity_done;
  assign o_err         = r_err;

endmodule

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 3-output router.
// Optional macro PARITY_ERR_CNT_EN enables the saturating parity-error counter
// on err_cnt; when undefined err_cnt reads zero.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   pkt_valid, data_in     source packet-valid and byte
//   fifo_full              selected output FIFO full
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                          one-hot FSM state strobes
//   dout                   registered byte to the output FIFO
//   parity_done            parity byte captured
//   low_pkt_valid          pkt_valid fell while loading data
//   err                    parity mismatch for current packet
//   err_cnt                saturating parity-error count
module router_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [7:0]            err_cnt
);

  logic [DATA_WIDTH-1:0] r_header_hold;
  logic [DATA_WIDTH-1:0] r_full_hold;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_low_pkt_valid;
  logic                  w_hdr_capture;

  assign w_hdr_capture = detect_add && pkt_valid && addr_valid(data_in[ADDR_MSB:ADDR_LSB]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_header_hold   <= '0;
      r_full_hold     <= '0;
      r_dout          <= '0;
      r_low_pkt_valid <= 1'b0;
    end else begin
      if (w_hdr_capture)
        r_header_hold <= data_in;

      // A byte presented while the FIFO is full is parked in full_hold and
      // replayed to dout in LOAD_AFTER_FULL.
      if (lfd_state)
        r_dout <= r_header_hold;
      else if (ld_state && !fifo_full)
        r_dout <= data_in;
      else if (ld_state && fifo_full)
        r_full_hold <= data_in;
      else if (laf_state)
        r_dout <= r_full_hold;

      if (ld_state && !pkt_valid)
        r_low_pkt_valid <= 1'b1;
      else if (rst_int_reg)
        r_low_pkt_valid <= 1'b0;
    end
  end

  router_parity_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_chk (
    .i_clk           (clk),
    .i_resetn        (resetn),
    .i_detect_add    (detect_add),
    .i_lfd_state     (lfd_state),
    .i_ld_state      (ld_state),
    .i_laf_state     (laf_state),
    .i_full_state    (full_state),
    .i_rst_int_reg   (rst_int_reg),
    .i_pkt_valid     (pkt_valid),
    .i_fifo_full     (fifo_full),
    .i_data_in       (data_in),
    .i_header_hold   (r_header_hold),
    .i_low_pkt_valid (r_low_pkt_valid),
    .o_parity_done   (parity_done),
    .o_err           (err),
    .o_err_cnt       (err_cnt)
  );

  assign dout          = r_dout;
  assign low_pkt_valid = r_low_pkt_valid;

endmodule

// File: tb/tb_router_reg.sv
module tb_router_reg;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;
  logic [7:0] err_cnt;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model: the last byte delivered to the FIFO, the last header
  // accepted, and the count of bad packets seen since reset.
  logic [7:0]  exp_dout;
  logic [7:0]  last_hdr;
  int unsigned exp_cnt;

  // Current packet payload and per-byte fifo_full pattern (bit plen = parity byte).
  logic [7:0]  pl [16];
  int unsigned plen;
  logic [16:0] fullmask;

  router_reg #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_err_cnt();
`ifdef PARITY_ERR_CNT_EN
    return 8'(exp_cnt > 255 ? 255 : exp_cnt);
`else
    return 8'd0;
`endif
  endfunction

  // Apply one FSM state for one clock, then let outputs settle past the edge.
  typedef enum int unsigned {S_IDLE, S_DA, S_LFD, S_LD, S_FULL, S_LAF, S_RIR} st_e;

  task automatic step(input st_e s, input logic pv, input logic ff, input logic [7:0] d);
    detect_add  = (s == S_DA);
    lfd_state   = (s == S_LFD);
    ld_state    = (s == S_LD);
    laf_state   = (s == S_LAF);
    full_state  = (s == S_FULL);
    rst_int_reg = (s == S_RIR);
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par);
    logic [7:0] xp;
    logic       exp_err;
    xp = hdr;
    for (int unsigned i = 0; i < plen; i++) xp ^= pl[i];
    exp_err = (xp != par);

    step(S_DA, 1'b1, 1'b0, hdr);
    last_hdr = hdr;
    check("da_err_clr", err, 0);
    check("da_pdone_clr", parity_done, 0);
    check("da_dout_hold", dout, exp_dout);

    step(S_LFD, 1'b1, 1'b0, pl[0]);
    exp_dout = hdr;
    check("lfd_dout_hdr", dout, exp_dout);

    for (int unsigned i = 0; i < plen; i++) begin
      if (!fullmask[i]) begin
        step(S_LD, 1'b1, 1'b0, pl[i]);
        exp_dout = pl[i];
        check("ld_dout", dout, exp_dout);
      end else begin
        step(S_LD, 1'b1, 1'b1, pl[i]);
        check("ld_full_hold", dout, exp_dout);
        step(S_FULL, 1'b1, 1'b0, pl[i]);
        check("full_dout_hold", dout, exp_dout);
        step(S_LAF, 1'b1, 1'b0, pl[i]);
        exp_dout = pl[i];
        check("laf_dout", dout, exp_dout);
        check("laf_no_pdone", parity_done, 0);
      end
    end

    if (!fullmask[plen]) begin
      step(S_LD, 1'b0, 1'b0, par);
      exp_dout = par;
      check("par_dout", dout, exp_dout);
      check("par_pdone", parity_done, 1);
      check("par_lowpv", low_pkt_valid, 1);
    end else begin
      step(S_LD, 1'b0, 1'b1, par);
      check("parf_dout_hold", dout, exp_dout);
      check("parf_pdone_lo", parity_done, 0);
      check("parf_lowpv", low_pkt_valid, 1);
      step(S_FULL, 1'b0, 1'b0, par);
      check("parf_full_pdone", parity_done, 0);
      step(S_LAF, 1'b0, 1'b0, par);
      exp_dout = par;
      check("parf_laf_dout", dout, exp_dout);
      check("parf_laf_pdone", parity_done, 1);
    end

    check("pre_rir_err", err, 0);
    step(S_RIR, 1'b0, 1'b0, 8'h00);
    check("rir_err", err, exp_err);
    check("rir_lowpv_clr", low_pkt_valid, 0);
    if (exp_err) exp_cnt++;

    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    check("idle_err_hold", err, exp_err);
    check("idle_dout_hold", dout, exp_dout);
    check("err_cnt", err_cnt, exp_err_cnt());
  endtask

  task automatic set_payload3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    plen = 3; pl[0] = a; pl[1] = b; pl[2] = c;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    exp_dout = 8'h00; last_hdr = 8'h00; exp_cnt = 0;
    fullmask = '0; plen = 0;
    resetn = 1'b0;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_pdone", parity_done, 0);
    check("rst_lowpv", low_pkt_valid, 0);
    check("rst_err", err, 0);
    check("rst_errcnt", err_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    step(S_IDLE, 1'b0, 1'b0, 8'h00);

    // Good packet
    set_payload3(8'h11, 8'h22, 8'h33); fullmask = '0;
    send_pkt(8'h0D, 8'h0D);
    // Bad parity
    send_pkt(8'h0D, 8'hFF);
    // FIFO full while byte 22 is presented
    fullmask = 17'b0010;
    send_pkt(8'h0D, 8'h0D);
    // FIFO full on the parity byte, good and bad
    fullmask = 17'b1000;
    send_pkt(8'h0D, 8'h0D);
    send_pkt(8'h0D, 8'h5A);

    // Invalid address: header_hold must keep the previous header
    step(S_DA, 1'b1, 1'b0, 8'h07);
    check("inv_dout_hold", dout, exp_dout);
    step(S_LFD, 1'b1, 1'b0, 8'h00);
    exp_dout = last_hdr;
    check("inv_hdr_kept", dout, exp_dout);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);

    // Randomised packets
    for (int n = 0; n < 40; n++) begin
      logic [7:0] hdr, xp, par;
      plen = $urandom_range(1, 8);
      hdr  = {6'(plen), 2'($urandom_range(0, 2))};
      xp   = hdr;
      for (int unsigned i = 0; i < plen; i++) begin
        pl[i] = 8'($urandom);
        xp ^= pl[i];
      end
      fullmask = '0;
      for (int unsigned i = 0; i <= plen; i++)
        fullmask[i] = ($urandom_range(0, 3) == 0);
      par = ($urandom_range(0, 2) == 0) ? (xp ^ 8'($urandom_range(1, 255))) : xp;
      send_pkt(hdr, par);
    end

    // Asynchronous reset in the middle of a payload
    set_payload3(8'h11, 8'h22, 8'h33); fullmask = '0;
    step(S_DA, 1'b1, 1'b0, 8'h0D);
    step(S_LFD, 1'b1, 1'b0, 8'h11);
    step(S_LD, 1'b1, 1'b0, 8'h11);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_pdone", parity_done, 0);
    check("arst_lowpv", low_pkt_valid, 0);
    check("arst_err", err, 0);
    check("arst_errcnt", err_cnt, 0);
    exp_dout = 8'h00; exp_cnt = 0;
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    send_pkt(8'h0D, 8'h0D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 3-output router, directly downstream of the router FSM.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the input byte stream.
- Produces the byte written into the selected output FIFO (dout), holds the header and any byte arriving while the FIFO is full, and computes and checks packet parity.
- Returns parity_done and low_pkt_valid to the FSM and err to the top level.

Parameters:
DATA_WIDTH, 8, byte width of data_in/dout (header: [1:0] = destination address, [DATA_WIDTH-1:2] = payload length)

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source packet-valid; low on the parity byte
data_in  input  DATA_WIDTH  source byte (header, payload, parity)
fifo_full  input  1  selected output FIFO full
detect_add  input  1  FSM in DECODE_ADDRESS
lfd_state  input  1  FSM in LOAD_FIRST_DATA
ld_state  input  1  FSM in LOAD_DATA
laf_state  input  1  FSM in LOAD_AFTER_FULL
full_state  input  1  FSM in FIFO_FULL_STATE
rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR
dout  output  DATA_WIDTH  byte to output FIFO (registered)
parity_done  output  1  parity byte captured
low_pkt_valid  output  1  pkt_valid fell while loading data
err  output  1  parity mismatch for current packet
err_cnt  output  8  saturating parity-error count (see Optional Feature)

Behaviour:
- Reset (resetn=0, asynchronous): dout, header_hold, full_hold, int_parity, pkt_parity = 0; parity_done, low_pkt_valid, err = 0; err_cnt = 0. A mid-packet reset discards all packet state; the next header starts clean.
- Header capture: detect_add && pkt_valid && data_in[1:0] != 2'b11 -> header_hold <= data_in. Address 3 is never captured.
- dout updates, in priority order:
  - lfd_state -> dout <= header_hold.
  - ld_state && !fifo_full -> dout <= data_in.
  - ld_state && fifo_full -> full_hold <= data_in, dout holds.
  - laf_state -> dout <= full_hold.
  - Otherwise dout holds its value.
- Latency: one cycle from data_in to dout in LOAD_DATA; header appears on dout one cycle after lfd_state.
- int_parity:
  - detect_add -> 0.
  - lfd_state -> int_parity ^ header_hold.
  - ld_state && pkt_valid && !full_state -> int_parity ^ data_in.
  - The parity byte is never accumulated.
- parity strobe: (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_pkt_valid && !parity_done). On the strobe: pkt_parity <= data_in and parity_done <= 1.
- parity_done clears on detect_add. detect_add wins if both occur in the same cycle (cannot occur with a legal FSM).
- low_pkt_valid: set on ld_state && !pkt_valid; cleared on rst_int_reg. Set wins on a simultaneous event.
- err:
  - Cleared on detect_add.
  - In any cycle with parity_done=1 and rst_int_reg=1: err <= (int_parity != pkt_parity).
  - Holds until the next detect_add.
- fifo_full during the parity byte: pkt_parity is captured later through the laf_state path. The check occurs on the eventual rst_int_reg cycle.
- The FSM strobes are one-hot by construction; behaviour with more than one strobe asserted is unspecified.

Optional Feature:
- Macro PARITY_ERR_CNT_EN.
- Defined: 8-bit err_cnt increments by 1 on each 0->1 transition of err, saturates at 255, and clears only on reset.
- Undefined: err_cnt is tied to 0 and no counter logic is instantiated. All other behaviour is identical.

Decomposition:
- Shared package router_pkg holds:
  - DATA_WIDTH default.
  - ADDR_INVALID = 2'b11.
  - Header field positions: ADDR_LSB=0, ADDR_MSB=1, LEN_LSB=2.
- One sub-module, router_parity_chk, owns int_parity, pkt_parity, parity_done and err (and err_cnt under the macro).
- The top router_reg owns header_hold, full_hold, dout and low_pkt_valid.

Test Plan:
- Good packet: header 8'h0D (addr 1, len 3), payload 11,22,33, parity 0D^11^22^33 = 8'h0D.
  - dout sequence: 0D, 11, 22, 33, 0D.
  - parity_done=1 after the parity byte; err=0 during rst_int_reg.
- Bad parity: same packet with parity 8'hFF -> err=1 from the cycle after rst_int_reg until the next detect_add; err_cnt=1 with PARITY_ERR_CNT_EN.
- FIFO full mid-payload: fifo_full=1 while byte 22 is presented in ld_state.
  - dout holds 11; full_hold=22.
  - In laf_state, dout=22; parity still matches, err=0.
- Full on parity byte: fifo_full=1 when pkt_valid falls.
  - low_pkt_valid=1, parity_done=0.
  - After laf_state: parity_done=1 and pkt_parity is captured; err is correct.
- Invalid address: detect_add with data_in=8'h07 (addr 3) -> header_hold unchanged, dout unchanged.
- Async reset mid-payload: resetn=0 between clock edges -> all outputs 0 immediately. Then a good packet yields err=0, and err_cnt remains 0 under the macro.
